bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have one parameter: BIN_W, default 10, binary input width; legal range 4..10.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request a conversion; level-sampled only while idle.
REQ-005 BIN  input  BIN_W  unsigned binary value to convert; sampled on the accepting edge only.
REQ-006 BUSY  output  1  high while a conversion is in progress.
REQ-007 DONE  output  1  one-cycle pulse; new digits valid.
REQ-008 OVF  output  1  last accepted value exceeded 999; held until next DONE.
REQ-009 HUND, TENS, ONES  output  4 each  registered BCD digits, values 0..9, feeding the display mux digit inputs.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT, LOAD.
- IDLE -> SHIFT when START=1.
- SHIFT -> LOAD after exactly BIN_W shift edges.
- LOAD -> IDLE unconditionally.
REQ-011 On the accepting edge E0, the block SHALL:
- capture BIN into a BIN_W-bit shift register;
- clear the 12-bit BCD scratch;
- load the iteration counter with BIN_W.
REQ-012 Each SHIFT edge SHALL apply the add-3 correction to every scratch digit >=5, then shift {scratch,shiftreg} left one bit.
REQ-013 The LOAD edge E(BIN_W+1) SHALL register the scratch digits into HUND/TENS/ONES and set DONE=1 for exactly the following cycle.
REQ-014 For BIN_W=10, latency from the START-sampling edge to DONE asserted SHALL be 11 edges.
REQ-015 BUSY SHALL be decoded from the state register: 1 in SHIFT and LOAD, 0 in IDLE.
REQ-016 HUND/TENS/ONES SHALL hold their previous values throughout a conversion and change only on the LOAD edge.
REQ-017 If the captured value is >999, the LOAD edge SHALL force the digits to 9,9,9 and set OVF=1; otherwise it SHALL clear OVF.
REQ-018 START while BUSY=1 SHALL be ignored; it is not queued.
REQ-019 START held high SHALL restart a conversion every BIN_W+2 cycles: the DONE cycle is IDLE and accepts the next request.
REQ-020 BIN changes after E0 SHALL not affect the result in progress.

Reset
REQ-021 RST=1 at an edge SHALL force:
- state IDLE; BUSY=0; DONE=0; OVF=0;
- HUND=TENS=ONES=0; scratch, shift register and counter to 0.
REQ-022 RST SHALL take priority over START and over any in-progress conversion; an aborted conversion SHALL produce no DONE pulse.

Structure
REQ-023 A shared package SHALL hold:
- state encoding constants (IDLE, SHIFT, LOAD);
- the BIN_W default;
- MAX_DEC = 999;
- BCD_W = 4.
REQ-024 A single combinational sub-module, BCD_ADD3 (4-bit in, 4-bit out: +3 if >=5 else pass-through), SHALL be instantiated once per scratch digit.
REQ-025 All outputs SHALL be registered except BUSY, which is a state-register decode.

Verification
REQ-026 Reset, then BIN=0, START pulse -> DONE at edge 11; digits 0,0,0; OVF=0.
REQ-027 BIN=255 -> 2,5,5; BIN=999 -> 9,9,9; OVF=0 for both; digits unchanged until the DONE cycle.
REQ-028 BIN=1000, then BIN=1023 -> 9,9,9 with OVF=1; a following BIN=7 -> 0,0,7 with OVF cleared.
REQ-029 START=1 again at edge 4 of a conversion with BIN=123, and BIN changed to 456 at the same time -> single DONE; result 1,2,3.
REQ-030 RST asserted at edge 6 of a conversion -> outputs 0 next cycle; no DONE; next START with BIN=42 -> 0,4,2 at edge 11.
REQ-031 START held high with BIN=321 -> DONE pulses every 12 cycles, digits 3,2,1.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Holds the state encoding, default input width, decimal ceiling and digit width.
package bin_to_bcd_seq_pkg;

  localparam int unsigned BIN_W_DEF = 10;
  localparam int unsigned MAX_DEC   = 999;
  localparam int unsigned BCD_W     = 4;
  localparam int unsigned DIG_N     = 3;
  localparam int unsigned SCR_W     = BCD_W * DIG_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] hund;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_t;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// BCD add-3 correction for one double-dabble digit (combinational).
// Ports: dig_i - scratch digit before the shift
//        dig_o - digit + 3 when dig_i >= 5, otherwise dig_i unchanged
module bin_to_bcd_seq_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] dig_i,
  output logic [BCD_W-1:0] dig_o
);

  always_comb begin
    dig_o = dig_i;
    if (dig_i >= BCD_W'(5)) begin
      dig_o = BCD_W'(dig_i + BCD_W'(3));
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock).
// Ports: clk_i   - clock, rising edge
//        rst_i   - synchronous active-high reset
//        start_i - conversion request, sampled only while idle
//        bin_i   - unsigned value, captured on the accepting edge
//        busy_o  - conversion in progress (state decode)
//        done_o  - one-cycle pulse, new digits valid
//        ovf_o   - last accepted value exceeded 999 (digits forced to 999)
//        hund_o/tens_o/ones_o - registered BCD digits
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W = BIN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [BCD_W-1:0] hund_o,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sreg_q, sreg_d;
  logic [SCR_W-1:0]   scr_q, scr_d, scr_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               big_q, big_d;
  bcd_t               dig_q, dig_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  // Add-3 correction applied to every scratch digit ahead of each shift
  for (genvar g = 0; g < DIG_N; g++) begin : g_add3
    bin_to_bcd_seq_add3 u_add3 (
      .dig_i (scr_q[g*BCD_W +: BCD_W]),
      .dig_o (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the counter reaching 1 marks the last shift edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_o = (state_q != ST_IDLE);
  end

  // Datapath next values
  always_comb begin
    sreg_d = sreg_q;
    scr_d  = scr_q;
    cnt_d  = cnt_q;
    big_d  = big_q;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sreg_d = bin_i;
          scr_d  = '0;
          cnt_d  = CNT_W'(BIN_W);
          // 12-bit scratch cannot represent >999, so decide overflow at capture
          big_d  = (32'(bin_i) > MAX_DEC);
        end
      end
      ST_SHIFT: begin
        {scr_d, sreg_d} = {scr_adj, sreg_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_LOAD: begin
        done_d = 1'b1;
        ovf_d  = big_q;
        if (big_q) begin
          dig_d = '{hund: BCD_W'(9), tens: BCD_W'(9), ones: BCD_W'(9)};
        end else begin
          dig_d = scr_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      big_q  <= 1'b0;
      dig_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      scr_q  <= scr_d;
      cnt_q  <= cnt_d;
      big_q  <= big_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign hund_o = dig_q.hund;
  assign tens_o = dig_q.tens;
  assign ones_o = dig_q.ones;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected digits,
// a negedge monitor pops and compares on every DONE pulse.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] bin;
  logic       busy, done, ovf;
  logic [3:0] hund, tens, ones;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t last_exp;

  bin_to_bcd_seq #(.BIN_W(10)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .bin_i   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf),
    .hund_o  (hund),
    .tens_o  (tens),
    .ones_o  (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pack_out();
    return int'({hund, tens, ones, ovf});
  endfunction

  // Monitor: each DONE pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_digits", pack_out(), int'(e));
      end
    end
  end

  // One conversion; optional re-request of START (with new BIN) at edge restart_at
  task automatic run(input logic [9:0] b, input exp_t e, input int restart_at);
    int  n;
    bit  got;
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~b;
    n     = 0;
    got   = 1'b0;
    while (n < 20 && !got) begin
      if (restart_at != 0 && n == restart_at - 1) begin
        start = 1'b1;
        bin   = 10'd456;
      end
      @(posedge clk);
      n++;
      #1;
      if (restart_at != 0 && n == restart_at) start = 1'b0;
      if (done) begin
        got = 1'b1;
      end else begin
        check("digits_held", pack_out(), int'(last_exp));
        check("busy_during", int'(busy), 1);
      end
    end
    check("done_latency", got ? n : -1, 11);
    last_exp = e;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", pack_out(), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("reset_over_start", int'(busy), 0);
    start = 1'b0;
    rst   = 1'b0;

    run(10'd0,    '{h:4'd0, t:4'd0, o:4'd0, ovf:1'b0}, 0);
    run(10'd255,  '{h:4'd2, t:4'd5, o:4'd5, ovf:1'b0}, 0);
    run(10'd999,  '{h:4'd9, t:4'd9, o:4'd9, ovf:1'b0}, 0);
    run(10'd1000, '{h:4'd9, t:4'd9, o:4'd9, ovf:1'b1}, 0);
    run(10'd1023, '{h:4'd9, t:4'd9, o:4'd9, ovf:1'b1}, 0);
    run(10'd7,    '{h:4'd0, t:4'd0, o:4'd7, ovf:1'b0}, 0);
    run(10'd123,  '{h:4'd1, t:4'd2, o:4'd3, ovf:1'b0}, 4);
    @(posedge clk);
    #1;
    check("ignored_start_busy", int'(busy), 0);

    // Abort a conversion with reset sampled at edge 6
    @(negedge clk);
    bin   = 10'd500;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_outputs", pack_out(), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    last_exp = '0;
    repeat (14) @(posedge clk);

    run(10'd42, '{h:4'd0, t:4'd4, o:4'd2, ovf:1'b0}, 0);

    // START held high: DONE every 12 cycles
    begin
      int n;
      int k;
      @(negedge clk);
      bin   = 10'd321;
      start = 1'b1;
      repeat (3) sb.push_back('{h:4'd3, t:4'd2, o:4'd1, ovf:1'b0});
      @(posedge clk);
      n = 0;
      k = 0;
      while (n < 45 && k < 3) begin
        @(posedge clk);
        n++;
        #1;
        if (done) begin
          k++;
          check("held_period", n, 12 * k - 1);
          if (k == 3) start = 1'b0;
        end
      end
      start = 1'b0;
      check("held_done_count", k, 3);
    end

    repeat (15) @(posedge clk);
    #1;
    check("final_idle", int'(busy), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
